// File: rtl/spi_resp_pkg.sv
// spi_resp_pkg: opcodes, FSM state encoding and wire-format constants for the SPI RAM responder
package spi_resp_pkg;

    localparam logic [7:0] OP_READ      = 8'h03;
    localparam logic [7:0] OP_WRITE     = 8'h02;
    localparam logic [7:0] OP_FAST_READ = 8'h0B;

    localparam int ADDR_BITS_WIRE = 24;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        RD_DATA,
        WR_DATA,
        IGNORE
    } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// spi_in_sync: synchronises SPI CLK/CS_N/MOSI into clk and flags CLK and CS_N edges
module spi_in_sync
    import spi_resp_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic i_sck,
    input  logic i_cs_n,
    input  logic i_mosi,
    output logic o_cs_n,
    output logic o_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_cs_rise,
    output logic o_cs_fall
);

    logic [SYNC_STAGES-1:0] r_sck;
    logic [SYNC_STAGES-1:0] r_cs;
    logic [SYNC_STAGES-1:0] r_mosi;
    logic                   r_sck_d;
    logic                   r_cs_d;

    // synchroniser chains plus one delayed copy for edge detection; CS_N resets deselected
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sck   <= '0;
            r_cs    <= '1;
            r_mosi  <= '0;
            r_sck_d <= 1'b0;
            r_cs_d  <= 1'b1;
        end else begin
            r_sck   <= {r_sck[SYNC_STAGES-2:0], i_sck};
            r_cs    <= {r_cs[SYNC_STAGES-2:0], i_cs_n};
            r_mosi  <= {r_mosi[SYNC_STAGES-2:0], i_mosi};
            r_sck_d <= r_sck[SYNC_STAGES-1];
            r_cs_d  <= r_cs[SYNC_STAGES-1];
        end
    end

    assign o_cs_n     = r_cs[SYNC_STAGES-1];
    assign o_mosi     = r_mosi[SYNC_STAGES-1];
    assign o_sck_rise = r_sck[SYNC_STAGES-1] & ~r_sck_d;
    assign o_sck_fall = ~r_sck[SYNC_STAGES-1] & r_sck_d;
    assign o_cs_rise  = r_cs[SYNC_STAGES-1] & ~r_cs_d;
    assign o_cs_fall  = ~r_cs[SYNC_STAGES-1] & r_cs_d;

endmodule

// File: rtl/spi_ram_responder.sv
// spi_ram_responder: SPI mode-0 target serving READ/WRITE on an internal byte array; FAST_READ_EN adds 0x0B with 8 dummy clocks
module spi_ram_responder
    import spi_resp_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int ADDR_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic CLK,
    input  logic CS_N,
    input  logic MOSI,
    output logic MISO,
    output logic MISO_OE,
    output logic active,
    output logic cmd_err,
    output logic wr_strobe
);

    logic              w_sck_rise;
    logic              w_sck_fall;
    logic              w_cs_n;
    logic              w_cs_rise;
    logic              w_cs_fall;
    logic              w_mosi;
    state_t            r_state;
    state_t            w_state_nxt;
    logic [4:0]        r_cnt;
    logic [6:0]        r_shift;
    logic [ADDR_W-2:0] r_addr;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] w_ptr_inc;
    logic [7:0]        r_tx;
    logic [7:0]        w_byte;
    logic              r_is_wr;
    logic              r_miso;
    logic              r_cmd_err;
    logic              r_wr_strobe;
    logic              w_fast;
    logic              w_op_ok;
    logic              w_last;
    logic              w_wr_en;
    logic [7:0]        r_mem [DEPTH];

    spi_in_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .resetn     (resetn),
        .i_sck      (CLK),
        .i_cs_n     (CS_N),
        .i_mosi     (MOSI),
        .o_cs_n     (w_cs_n),
        .o_mosi     (w_mosi),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_cs_rise  (w_cs_rise),
        .o_cs_fall  (w_cs_fall)
    );

`ifdef FAST_READ_EN
    logic r_fast;
    assign w_fast  = r_fast;
    assign w_op_ok = w_byte == OP_READ || w_byte == OP_WRITE || w_byte == OP_FAST_READ;
`else
    assign w_fast  = 1'b0;
    assign w_op_ok = w_byte == OP_READ || w_byte == OP_WRITE;
`endif

    // only the low ADDR_W address bits are kept, so higher wire bits alias naturally
    assign w_byte     = {r_shift, w_mosi};
    assign w_addr_nxt = {r_addr, w_mosi};
    assign w_ptr_inc  = r_ptr + 1'b1;
    assign w_last     = w_sck_rise && (r_cnt == ((r_state == ADDR) ? 5'(ADDR_BITS_WIRE - 1) : 5'd7));
    assign w_wr_en    = !w_cs_n && r_state == WR_DATA && w_last;
    assign MISO_OE    = !w_cs_n;
    assign MISO       = r_miso & MISO_OE;
    assign active     = r_state != IDLE;
    assign cmd_err    = r_cmd_err;
    assign wr_strobe  = r_wr_strobe;

    // transaction state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    // next state; a deselected CS_N overrides everything, including a coincident CLK edge
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_state_nxt = CMD;
            CMD:     if (w_last) w_state_nxt = w_op_ok ? ADDR : IGNORE;
            ADDR:    if (w_last) w_state_nxt = r_is_wr ? WR_DATA : (w_fast ? DUMMY : RD_DATA);
`ifdef FAST_READ_EN
            DUMMY:   if (w_last) w_state_nxt = RD_DATA;
`endif
            default: w_state_nxt = r_state;
        endcase
        if (w_cs_n) w_state_nxt = IDLE;
    end

    // shift registers, bit counter, pointer and pulse outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt       <= '0;
            r_shift     <= '0;
            r_addr      <= '0;
            r_ptr       <= '0;
            r_tx        <= '0;
            r_is_wr     <= 1'b0;
            r_miso      <= 1'b0;
            r_cmd_err   <= 1'b0;
            r_wr_strobe <= 1'b0;
`ifdef FAST_READ_EN
            r_fast      <= 1'b0;
`endif
        end else begin
            r_cmd_err   <= 1'b0;
            r_wr_strobe <= 1'b0;
            if (w_cs_n) begin
                r_cnt <= '0;
                if (w_cs_rise) r_miso <= 1'b0;
            end else begin
                case (r_state)
                    CMD: if (w_sck_rise) begin
                        r_shift <= w_byte[6:0];
                        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                        if (w_last) begin
                            r_is_wr   <= w_byte == OP_WRITE;
                            r_cmd_err <= !w_op_ok;
`ifdef FAST_READ_EN
                            r_fast    <= w_byte == OP_FAST_READ;
`endif
                        end
                    end
                    ADDR: if (w_sck_rise) begin
                        r_addr <= w_addr_nxt[ADDR_W-2:0];
                        r_cnt  <= w_last ? '0 : r_cnt + 1'b1;
                        if (w_last) begin
                            r_ptr <= w_addr_nxt;
                            r_tx  <= r_mem[w_addr_nxt];
                        end
                    end
`ifdef FAST_READ_EN
                    DUMMY: if (w_sck_rise) begin
                        r_cnt <= w_last ? '0 : r_cnt + 1'b1;
                        if (w_last) r_tx <= r_mem[r_ptr];
                    end
`endif
                    RD_DATA: if (w_sck_fall) begin
                        r_miso <= r_tx[7];
                        r_cnt  <= (r_cnt == 5'd7) ? '0 : r_cnt + 1'b1;
                        if (r_cnt == 5'd7) begin
                            r_ptr <= w_ptr_inc;
                            r_tx  <= r_mem[w_ptr_inc];
                        end else begin
                            r_tx <= {r_tx[6:0], 1'b0};
                        end
                    end
                    WR_DATA: if (w_sck_rise) begin
                        r_shift <= w_byte[6:0];
                        r_cnt   <= w_last ? '0 : r_cnt + 1'b1;
                        if (w_last) begin
                            r_wr_strobe <= 1'b1;
                            r_ptr       <= w_ptr_inc;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // byte array; contents survive reset
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_ptr] <= w_byte;
    end

endmodule

// File: tb/tb_spi_ram_responder.sv
// tb_spi_ram_responder: directed SPI transactions against spi_ram_responder (optionally built with FAST_READ_EN)
module tb_spi_ram_responder;

    localparam int HALF = 8;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic CLK = 1'b0;
    logic CS_N = 1'b1;
    logic MOSI = 1'b0;
    logic MISO;
    logic MISO_OE;
    logic active;
    logic cmd_err;
    logic wr_strobe;

    int n_checks = 0;
    int n_fail = 0;
    int wr_cnt = 0;
    int err_cnt = 0;

    spi_ram_responder dut (
        .clk       (clk),
        .resetn    (resetn),
        .CLK       (CLK),
        .CS_N      (CS_N),
        .MOSI      (MOSI),
        .MISO      (MISO),
        .MISO_OE   (MISO_OE),
        .active    (active),
        .cmd_err   (cmd_err),
        .wr_strobe (wr_strobe)
    );

    always #5 clk = ~clk;

    // count one-clk pulses
    always @(posedge clk) begin
        if (wr_strobe === 1'b1) wr_cnt <= wr_cnt + 1;
        if (cmd_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int n, output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < n; i++) begin
            MOSI = tx[7-i];
            tick(HALF);
            rx[7-i] = MISO;
            CLK = 1'b1;
            tick(HALF);
            CLK = 1'b0;
        end
    endtask

    task automatic cs_start();
        CS_N = 1'b0;
        tick(HALF);
    endtask

    task automatic cs_end(input int gap);
        tick(HALF);
        CS_N = 1'b1;
        MOSI = 1'b0;
        tick(gap);
    endtask

    task automatic send_hdr(input logic [7:0] op, input logic [23:0] addr);
        logic [7:0] rx;
        spi_bits(op, 8, rx);
        spi_bits(addr[23:16], 8, rx);
        spi_bits(addr[15:8], 8, rx);
        spi_bits(addr[7:0], 8, rx);
    endtask

    task automatic write_bytes(input logic [23:0] addr, input logic [15:0] data, input int nb);
        logic [7:0] rx;
        cs_start();
        send_hdr(8'h02, addr);
        spi_bits(data[15:8], 8, rx);
        if (nb > 1) spi_bits(data[7:0], 8, rx);
        cs_end(4);
    endtask

    task automatic read2(input logic [23:0] addr, input int gap, output logic [7:0] r0, output logic [7:0] r1);
        cs_start();
        send_hdr(8'h03, addr);
        spi_bits(8'h00, 8, r0);
        spi_bits(8'h00, 8, r1);
        cs_end(gap);
    endtask

    task automatic test_reset();
        tick(5);
        n_checks++; if (MISO !== 1'b0) begin n_fail++; $display("FAIL reset_miso: got %b expected 0", MISO); end
        n_checks++; if (MISO_OE !== 1'b0) begin n_fail++; $display("FAIL reset_oe: got %b expected 0", MISO_OE); end
        n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL reset_active: got %b expected 0", active); end
        n_checks++; if (cmd_err !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_err: got %b expected 0", cmd_err); end
        n_checks++; if (wr_strobe !== 1'b0) begin n_fail++; $display("FAIL reset_wr_strobe: got %b expected 0", wr_strobe); end
        resetn = 1'b1;
        tick(6);
        n_checks++; if (active !== 1'b0 || MISO_OE !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got active=%b oe=%b expected 0 0", active, MISO_OE); end
    endtask

    task automatic test_write_read();
        logic [7:0] r0, r1;
        int w0;
        w0 = wr_cnt;
        cs_start();
        n_checks++; if (active !== 1'b1 || MISO_OE !== 1'b1) begin n_fail++; $display("FAIL selected: got active=%b oe=%b expected 1 1", active, MISO_OE); end
        send_hdr(8'h02, 24'h000010);
        spi_bits(8'hA5, 8, r0);
        spi_bits(8'h5A, 8, r0);
        cs_end(4);
        n_checks++; if (wr_cnt - w0 !== 2) begin n_fail++; $display("FAIL wr_strobe_count: got %0d expected 2", wr_cnt - w0); end
        n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL deselect_idle: got %b expected 0", active); end
        read2(24'h000010, 4, r0, r1);
        n_checks++; if (r0 !== 8'hA5) begin n_fail++; $display("FAIL read_byte0: got %h expected a5", r0); end
        n_checks++; if (r1 !== 8'h5A) begin n_fail++; $display("FAIL read_byte1: got %h expected 5a", r1); end
    endtask

    task automatic test_wrap();
        logic [7:0] r0, r1;
        int w0;
        w0 = wr_cnt;
        write_bytes(24'h0000FF, 16'h1122, 2);
        n_checks++; if (wr_cnt - w0 !== 2) begin n_fail++; $display("FAIL wrap_wr_count: got %0d expected 2", wr_cnt - w0); end
        read2(24'h0000FF, 4, r0, r1);
        n_checks++; if (r0 !== 8'h11 || r1 !== 8'h22) begin n_fail++; $display("FAIL wrap_read: got %h %h expected 11 22", r0, r1); end
        read2(24'hABCD00, 4, r0, r1);
        n_checks++; if (r0 !== 8'h22) begin n_fail++; $display("FAIL alias_read_00: got %h expected 22", r0); end
        read2(24'hABCDFF, 4, r0, r1);
        n_checks++; if (r0 !== 8'h11 || r1 !== 8'h22) begin n_fail++; $display("FAIL alias_read_ff: got %h %h expected 11 22", r0, r1); end
    endtask

    task automatic test_bad_opcode();
        logic [7:0] rx, r0, r1;
        int e0, w0;
        e0 = err_cnt;
        w0 = wr_cnt;
        cs_start();
        spi_bits(8'h9F, 8, rx);
        for (int b = 0; b < 4; b++) begin
            spi_bits(8'hFF, 8, rx);
            n_checks++; if (rx !== 8'h00) begin n_fail++; $display("FAIL ignore_miso byte %0d: got %h expected 00", b, rx); end
        end
        n_checks++; if (active !== 1'b1) begin n_fail++; $display("FAIL ignore_active: got %b expected 1", active); end
        cs_end(4);
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL cmd_err_count: got %0d expected 1", err_cnt - e0); end
        n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL ignore_no_write: got %0d expected 0", wr_cnt - w0); end
        read2(24'h000010, 4, r0, r1);
        n_checks++; if (r0 !== 8'hA5 || r1 !== 8'h5A) begin n_fail++; $display("FAIL after_ignore_read: got %h %h expected a5 5a", r0, r1); end
    endtask

    task automatic test_partial_write();
        logic [7:0] rx, r0, r1;
        int w0;
        write_bytes(24'h000020, 16'h0000, 1);
        w0 = wr_cnt;
        cs_start();
        send_hdr(8'h02, 24'h000020);
        spi_bits(8'hFF, 5, rx);
        cs_end(4);
        n_checks++; if (wr_cnt - w0 !== 0) begin n_fail++; $display("FAIL partial_wr_strobe: got %0d expected 0", wr_cnt - w0); end
        read2(24'h000020, 4, r0, r1);
        n_checks++; if (r0 !== 8'h00) begin n_fail++; $display("FAIL partial_keep: got %h expected 00", r0); end
    endtask

    task automatic test_reset_mid_read();
        logic [7:0] rx, r0, r1;
        cs_start();
        send_hdr(8'h03, 24'h000011);
        spi_bits(8'h00, 3, rx);
        tick(4);
        n_checks++; if (rx !== 8'h40) begin n_fail++; $display("FAIL partial_read_bits: got %h expected 40", rx); end
        n_checks++; if (MISO !== 1'b1) begin n_fail++; $display("FAIL pre_reset_miso: got %b expected 1", MISO); end
        resetn = 1'b0;
        #1;
        n_checks++; if (MISO !== 1'b0 || MISO_OE !== 1'b0 || active !== 1'b0) begin n_fail++; $display("FAIL async_reset: got miso=%b oe=%b active=%b expected 0 0 0", MISO, MISO_OE, active); end
        CS_N = 1'b1;
        MOSI = 1'b0;
        tick(3);
        resetn = 1'b1;
        tick(4);
        read2(24'h000010, 4, r0, r1);
        n_checks++; if (r0 !== 8'hA5) begin n_fail++; $display("FAIL read_after_reset: got %h expected a5", r0); end
    endtask

    task automatic test_fast_read();
        logic [7:0] rx, rd;
        int e0;
        e0 = err_cnt;
        cs_start();
        send_hdr(8'h0B, 24'h000010);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 8, rd);
        cs_end(4);
        n_checks++; if (rx !== 8'h00) begin n_fail++; $display("FAIL fast_dummy_miso: got %h expected 00", rx); end
`ifdef FAST_READ_EN
        n_checks++; if (rd !== 8'hA5) begin n_fail++; $display("FAIL fast_read_data: got %h expected a5", rd); end
        n_checks++; if (err_cnt - e0 !== 0) begin n_fail++; $display("FAIL fast_cmd_err: got %0d expected 0", err_cnt - e0); end
`else
        n_checks++; if (rd !== 8'h00) begin n_fail++; $display("FAIL fast_unsupported_miso: got %h expected 00", rd); end
        n_checks++; if (err_cnt - e0 !== 1) begin n_fail++; $display("FAIL fast_cmd_err: got %0d expected 1", err_cnt - e0); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [7:0] r0, r1;
        read2(24'h000011, 3, r0, r1);
        n_checks++; if (r0 !== 8'h5A) begin n_fail++; $display("FAIL b2b_first: got %h expected 5a", r0); end
        read2(24'h000010, 6, r0, r1);
        n_checks++; if (r0 !== 8'hA5 || r1 !== 8'h5A) begin n_fail++; $display("FAIL b2b_second: got %h %h expected a5 5a", r0, r1); end
        n_checks++; if (active !== 1'b0 || MISO !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got active=%b miso=%b expected 0 0", active, MISO); end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_wrap();
        test_bad_opcode();
        test_partial_write();
        test_reset_mid_read();
        test_fast_read();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_ram_responder.md
Name: spi_ram_responder

Overview:
SPI target (slave) that answers the same serial RAM command set our SPI RAM and flash mappers issue as initiators. Supported commands are READ 0x03 and WRITE 0x02, each followed by a 24-bit address. It is backed by an internal byte array. It gives the bench and the FPGA top a self-contained responder for the RAM/flash mapper, and lets an external host access a scratch memory. SPI mode 0, MSB first. All SPI inputs are oversampled in the clk domain.

Parameters:
DEPTH, 256, number of bytes in internal array (power of two)
ADDR_W, 8, log2(DEPTH); low ADDR_W bits of the 24-bit wire address are used
SYNC_STAGES, 2, synchroniser flops on CLK/CS_N/MOSI inputs

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
CLK  in  1  SPI clock from initiator
CS_N  in  1  SPI chip select, active low
MOSI  in  1  initiator-to-target data
MISO  out  1  target-to-initiator data
MISO_OE  out  1  high while selected (synchronised CS_N low); pad tri-state control
active  out  1  high while a transaction is in progress (state != IDLE)
cmd_err  out  1  one-clk pulse on unsupported opcode
wr_strobe  out  1  one-clk pulse when a byte is committed to the array

Behaviour:
- Reset (resetn low, async): state IDLE, all counters 0. MISO=0, MISO_OE=0, active=0, cmd_err=0, wr_strobe=0. Array contents are not reset.
- Clock ratio: f_clk >= 8 x f_CLK is required. Input latency is SYNC_STAGES+1 clk from pin to detected edge.
- Edges: rise/fall detected on synchronised CLK. Synchronised CS_N high forces IDLE on the next clk from any state.
- FSM: IDLE -> CMD on CS_N fall.
- CMD: shift 8 MOSI bits on CLK rises.
  - 0x03 -> ADDR (read).
  - 0x02 -> ADDR (write).
  - Any other opcode -> IGNORE and pulse cmd_err.
- ADDR: shift 24 bits, MSB first. On the 24th rise, latch ptr = addr[ADDR_W-1:0].
  - Read -> RD_DATA.
  - Write -> WR_DATA.
- RD_DATA:
  - Load shift register with mem[ptr]. Drive bit7 on MISO at the CLK fall following the 24th address rise.
  - Shift one bit per CLK fall.
  - After 8 falls, ptr increments and the next byte loads seamlessly.
- WR_DATA:
  - Shift MOSI on rises.
  - On the 8th rise, write mem[ptr] <= byte, pulse wr_strobe, increment ptr.
- IGNORE: MISO=0, no array access, until CS_N rises.
- Pointer wraps DEPTH-1 -> 0 (mod DEPTH), in both directions of use. Address bits above ADDR_W are ignored (aliasing).
- CS_N rise mid-byte: partial write byte is discarded. A partial read has no side effect. Bit counter is cleared.
- CS_N fall while not IDLE (glitch-free reselect after a short high): IDLE is entered first, then CMD. A CS_N high pulse shorter than 2 clk is unsupported.
- MISO holds its last value between falls. It is 0 when MISO_OE=0.
- Simultaneous CLK edge and CS_N rise in the same clk: CS_N wins, and the edge is ignored.

Optional Feature:
FAST_READ_EN
- Defined: opcode 0x0B is accepted. After the 24 address bits, the DUMMY state consumes 8 CLK rises with MISO=0. Data then follows exactly as in READ, with the first bit driven on the fall after the 8th dummy rise.
- Undefined: 0x0B is an unsupported opcode (IGNORE + cmd_err). The DUMMY state and its counter are not synthesised.

Decomposition:
- Package spi_resp_pkg:
  - opcode constants OP_READ=0x03, OP_WRITE=0x02, OP_FAST_READ=0x0B
  - state enum IDLE, CMD, ADDR, DUMMY, RD_DATA, WR_DATA, IGNORE
  - ADDR_BITS_WIRE=24
- Sub-module spi_in_sync: SYNC_STAGES synchroniser for CLK/CS_N/MOSI plus rise/fall pulse generation on CLK and CS_N. It is instantiated once.

Test Plan:
- Write 0x02,0x000010, data 0xA5,0x5A, then CS_N high. Read 0x03,0x000010 for 2 bytes -> MISO returns 0xA5,0x5A. wr_strobe pulses exactly twice.
- Write at 0x0000FF of bytes 0x11,0x22 -> mem[0xFF]=0x11 and mem[0x00]=0x22. Read from 0xFF for 2 bytes -> 0x11,0x22 (wrap).
- Opcode 0x9F -> cmd_err pulses once, MISO stays 0 for 32 further CLKs, array is unchanged. Next transaction works normally.
- Write 0x02,0x000020 with 0xFF, then CS_N raised after 5 data bits -> mem[0x20] keeps its prior value (0x00 after preload), and wr_strobe never pulses.
- Assert resetn low mid-read at bit 3 of data -> MISO=0, MISO_OE=0, active=0 immediately. After release, read of 0x000010 returns 0xA5.
- With FAST_READ_EN: 0x0B,0x000010, 8 dummy clocks -> 0xA5. Without it: same stimulus -> cmd_err pulse and MISO=0.
